// File: rtl/instr_fetch_pkg.sv
// Shared fetch-unit definitions: opcode/funct types, NOP/HALT words, branch LUT.
// The LUT exists only when BRANCH_LUT_EN is defined.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    REG   = 3'b000,
    ARITH = 3'b001,
    SHIFT = 3'b010,
    HARD  = 3'b011,
    SLT   = 3'b100,
    XOR   = 3'b101,
    AND   = 3'b110,
    OR    = 3'b111
  } op_code;

  typedef enum logic [1:0] {
    REDEF  = 2'b00,
    LW     = 2'b01,
    SW     = 2'b10,
    BRANCH = 2'b11
  } func_code;

  localparam logic [8:0] NOP_INSTR  = 9'h0CC;
  localparam logic [8:0] HALT_INSTR = 9'h0CC;
  localparam int         ROM_DEPTH  = 1024;

`ifdef BRANCH_LUT_EN
  localparam logic [9:0] BRANCH_LUT [16] = '{
    10'h000, 10'h010, 10'h020, 10'h030,
    10'h040, 10'h050, 10'h060, 10'h070,
    10'h100, 10'h120, 10'h140, 10'h160,
    10'h200, 10'h280, 10'h30A, 10'h3F0
  };
`endif

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: run control, issued instruction, status and ROM image load.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [8:0]  instr;
  logic        instr_valid;
  logic [9:0]  pc;
  logic        busy;
  logic        done;
  logic [15:0] instr_count;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [8:0]  load_data;

  modport master (
    input  start, stall, branch_taken,
    input  load_we, load_addr, load_data,
    output instr, instr_valid, pc,
    output busy, done, instr_count
  );

  modport slave (
    output start, stall, branch_taken,
    output load_we, load_addr, load_data,
    input  instr, instr_valid, pc,
    input  busy, done, instr_count
  );

endinterface

// File: rtl/instr_fetch_rom.sv
// 1024 x 9 program store, combinational read; the machine_code.txt image
// is streamed in by the loader through the write port.
module instr_rom
  import instr_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       we_i,
  input  logic [9:0] waddr_i,
  input  logic [8:0] wdata_i,
  input  logic [9:0] raddr_i,
  output logic [8:0] rdata_o
);

  logic [8:0] mem_q [ROM_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM (IDLE/RUN/DONE), zero-latency issue from instr_rom.
// BRANCH_LUT_EN selects a table branch target instead of pc-relative.
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  instr_fetch_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic [9:0]  pc_q;
  logic [15:0] cnt_q;
  logic        busy_q;
  logic        done_q;

  logic [8:0]  rom_w;
  op_code      op;
  func_code    fn;
  logic        issue;
  logic        is_halt;
  logic        is_br;
  logic [9:0]  br_tgt;
  logic [9:0]  pc_d;

  instr_rom u_rom (
    .clk     (clk),
    .we_i    (bus.load_we),
    .waddr_i (bus.load_addr),
    .wdata_i (bus.load_data),
    .raddr_i (pc_q),
    .rdata_o (rom_w)
  );

  assign op      = op_code'(rom_w[8:6]);
  assign fn      = func_code'(rom_w[5:4]);
  assign issue   = (state_q == RUN) && !bus.stall && !reset;
  assign is_halt = (rom_w[8:2] == HALT_INSTR[8:2]);
  assign is_br   = (op == HARD) && (fn == BRANCH);

`ifdef BRANCH_LUT_EN
  assign br_tgt = BRANCH_LUT[rom_w[3:0]];
`else
  assign br_tgt = pc_q + {{6{rom_w[3]}}, rom_w[3:0]};
`endif

  always_comb begin
    pc_d = pc_q + 10'd1;
    if (is_br && bus.branch_taken) pc_d = br_tgt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q <= RUN;
            pc_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.stall) begin
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            // HALT freezes pc on its own address
            if (is_halt) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pc_q <= pc_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr       = issue ? rom_w : NOP_INSTR;
  assign bus.instr_valid = issue;
  assign bus.pc          = pc_q;
  assign bus.busy        = busy_q & ~reset;
  assign bus.done        = done_q & ~reset;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: halt, stall, branch, reset, wrap, saturation.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [8:0] ADD_W = 9'h001;
  localparam logic [8:0] XOR_W = 9'h140;
  localparam logic [8:0] BR_W  = 9'h0FE;
  localparam logic [8:0] HLT_W = 9'h0CC;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  instr_fetch_if bus();

  instr_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [8:0] d);
    bus.load_we   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    cyc();
    bus.load_we   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    #1;
    cyc();
    bus.start = 1'b0;
    #1;
  endtask

  logic [9:0] br_exp;

  initial begin
`ifdef BRANCH_LUT_EN
    br_exp = BRANCH_LUT[14];
`else
    br_exp = 10'd6;
`endif
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.load_we      = 1'b0;
    bus.load_addr    = '0;
    bus.load_data    = '0;

    for (int i = 0; i < 1024; i++) load(10'(i), ADD_W);
    load(10'd1, XOR_W);
    load(10'd2, HLT_W);
    load(10'd8, BR_W);
    #1;
    chk("rst_instr", 32'(bus.instr), 32'h0CC);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_pc", 32'(bus.pc), 0);
    chk("rst_cnt", 32'(bus.instr_count), 0);

    // Test 1: ADD, XOR, HALT
    reset = 1'b0;
    cyc();
    chk("idle_busy", 32'(bus.busy), 0);
    pulse_start();
    chk("t1_busy", 32'(bus.busy), 1);
    chk("t1_pc0", 32'(bus.pc), 0);
    chk("t1_i0", 32'(bus.instr), 32'(ADD_W));
    chk("t1_v0", 32'(bus.instr_valid), 1);
    cyc();
    chk("t1_pc1", 32'(bus.pc), 1);
    chk("t1_i1", 32'(bus.instr), 32'(XOR_W));
    cyc();
    chk("t1_pc2", 32'(bus.pc), 2);
    chk("t1_i2", 32'(bus.instr), 32'(HLT_W));
    chk("t1_v2", 32'(bus.instr_valid), 1);
    cyc();
    chk("t1_done", 32'(bus.done), 1);
    chk("t1_busy_lo", 32'(bus.busy), 0);
    chk("t1_cnt", 32'(bus.instr_count), 3);
    chk("t1_pc_hold", 32'(bus.pc), 2);
    chk("t1_vdone", 32'(bus.instr_valid), 0);
    chk("t1_idone", 32'(bus.instr), 32'h0CC);
    load(10'd2, ADD_W);
    chk("t1_pc_hold2", 32'(bus.pc), 2);

    // Restart from DONE, then Test 2: stall at pc 5
    pulse_start();
    chk("rs_done", 32'(bus.done), 0);
    chk("rs_cnt", 32'(bus.instr_count), 0);
    chk("rs_pc", 32'(bus.pc), 0);
    for (int i = 0; i < 5; i++) cyc();
    chk("t2_pc5", 32'(bus.pc), 5);
    bus.stall = 1'b1;
    #1;
    chk("t2_nop", 32'(bus.instr), 32'h0CC);
    chk("t2_v", 32'(bus.instr_valid), 0);
    cyc();
    chk("t2_pc_a", 32'(bus.pc), 5);
    chk("t2_cnt_a", 32'(bus.instr_count), 5);
    chk("t2_v_a", 32'(bus.instr_valid), 0);
    cyc();
    bus.stall = 1'b0;
    #1;
    chk("t2_pc_b", 32'(bus.pc), 5);
    chk("t2_cnt_b", 32'(bus.instr_count), 5);
    chk("t2_resume", 32'(bus.instr_valid), 1);
    cyc();
    chk("t2_pc6", 32'(bus.pc), 6);
    chk("t2_cnt6", 32'(bus.instr_count), 6);

    // Test 3: branch at pc 8, branch_taken ignored on non-branches
    bus.branch_taken = 1'b1;
    cyc();
    chk("t3_ign", 32'(bus.pc), 7);
    cyc();
    chk("t3_pc8", 32'(bus.pc), 8);
    chk("t3_ibr", 32'(bus.instr), 32'(BR_W));
    cyc();
    chk("t3_taken", 32'(bus.pc), 32'(br_exp));
    bus.branch_taken = 1'b0;
`ifdef BRANCH_LUT_EN
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    pulse_start();
    for (int i = 0; i < 8; i++) cyc();
`else
    cyc();
    cyc();
`endif
    chk("t3_pc8b", 32'(bus.pc), 8);
    cyc();
    chk("t3_fall", 32'(bus.pc), 9);

    // Test 4: reset mid-run at pc 20
    for (int i = 0; i < 11; i++) cyc();
    chk("t4_pc20", 32'(bus.pc), 20);
    reset = 1'b1;
    #1;
    chk("t4_v_in_rst", 32'(bus.instr_valid), 0);
    chk("t4_b_in_rst", 32'(bus.busy), 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("t4_pc0", 32'(bus.pc), 0);
    chk("t4_cnt0", 32'(bus.instr_count), 0);
    chk("t4_v0", 32'(bus.instr_valid), 0);
    cyc();
    chk("t4_idle_pc", 32'(bus.pc), 0);
    chk("t4_idle_b", 32'(bus.busy), 0);
    pulse_start();
    chk("t4_rerun", 32'(bus.pc), 0);
    chk("t4_rerun_v", 32'(bus.instr_valid), 1);
    cyc();
    chk("t4_pc1", 32'(bus.pc), 1);

    // Test 5: start ignored in RUN, wrap 3FF -> 0, restart from DONE
    for (int i = 0; i < 1022; i++) begin
      if (i == 100) bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
    end
    chk("t5_pc3ff", 32'(bus.pc), 32'h3FF);
    chk("t5_cnt", 32'(bus.instr_count), 1023);
    cyc();
    chk("t5_wrap", 32'(bus.pc), 0);
    chk("t5_busy", 32'(bus.busy), 1);
    bus.stall = 1'b1;
    load(10'd1, HLT_W);
    chk("t5_stall_pc", 32'(bus.pc), 0);
    chk("t5_cnt1024", 32'(bus.instr_count), 1024);
    bus.stall = 1'b0;
    #1;
    cyc();
    cyc();
    chk("t5_done", 32'(bus.done), 1);
    chk("t5_pc1", 32'(bus.pc), 1);
    chk("t5_cnt1026", 32'(bus.instr_count), 1026);
    load(10'd1, ADD_W);
    pulse_start();
    chk("t5_rs_done", 32'(bus.done), 0);
    chk("t5_rs_busy", 32'(bus.busy), 1);
    chk("t5_rs_cnt", 32'(bus.instr_count), 0);
    chk("t5_rs_pc", 32'(bus.pc), 0);

    // Test 6: saturation of instr_count
    for (int i = 0; i < 65534; i++) cyc();
    chk("t6_fffe", 32'(bus.instr_count), 32'hFFFE);
    cyc();
    chk("t6_ffff", 32'(bus.instr_count), 32'hFFFF);
    for (int i = 0; i < 4465; i++) cyc();
    chk("t6_sat", 32'(bus.instr_count), 32'hFFFF);
    chk("t6_busy", 32'(bus.busy), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, both named as below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle pulse that begins a program run at PC 0.
REQ-005 stall  input  1  hold the current PC and suppress issue this cycle.
REQ-006 branch_taken  input  1  ALU BNZ result for the instruction issued this cycle.
REQ-007 instr  output  9  instruction word to the control decoder.
REQ-008 instr_valid  output  1  instr is a real program instruction this cycle.
REQ-009 pc  output  10  address of the instruction currently presented.
REQ-010 busy  output  1  high while in state RUN.
REQ-011 done  output  1  high while in state DONE.
REQ-012 instr_count  output  16  number of instructions issued in the current run, saturating.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE + start -> RUN on the next edge with pc=0 and instr_count=0.
REQ-015 In RUN with stall=0, the block SHALL set instr=rom[pc] and instr_valid=1, and SHALL increment instr_count by 1, saturating at 16'hFFFF.
REQ-016 In RUN with stall=1, the block SHALL set instr=NOP (9'h0CC) and instr_valid=0, hold pc, and ignore branch_taken.
REQ-017 The HALT encoding is op=HARD, fun2=REDEF, instr[3:2]=2'b11; when HALT is issued in RUN, the next state SHALL be DONE with pc held, and HALT counts as issued.
REQ-018 Branch: when an op=HARD, fun2=BRANCH instruction is issued with branch_taken=1, next pc SHALL be the branch target; when branch_taken=0, next pc SHALL be pc+1.
REQ-019 For every other instruction issued in RUN, next pc SHALL be pc+1, and pc SHALL wrap from 10'h3FF to 10'h000 without a flag.
REQ-020 branch_taken SHALL be ignored unless the issued instruction is a branch.
REQ-021 In IDLE and DONE, the block SHALL drive instr=NOP and instr_valid=0; NOP is a no-op in the decoder (no register or memory write).
REQ-022 start SHALL be ignored in RUN; in DONE, start SHALL behave as in IDLE (restart at pc 0, instr_count cleared), and done SHALL fall on the same edge.
REQ-023 Issue latency SHALL be zero: the ROM read is combinational from pc.
REQ-024 stall and start asserted together in IDLE SHALL still enter RUN, and stall applies from the first RUN cycle.

Reset
REQ-025 Reset SHALL take priority over all inputs and force state=IDLE, pc=0, instr_count=0.
REQ-026 While in reset, outputs SHALL be instr=NOP, instr_valid=0, busy=0, done=0.
REQ-027 Reset asserted mid-RUN SHALL abandon the run with no further issue; a new start is required afterwards.

Configuration
REQ-028 With BRANCH_LUT_EN defined, the branch target SHALL be a 16-entry x 10-bit constant table indexed by instr[3:0].
REQ-029 Without BRANCH_LUT_EN, the branch target SHALL be pc plus sign-extended instr[3:0], modulo 1024.

Structure
REQ-030 The shared definitions package SHALL hold the typedefs op_code (REG=000, ARITH=001, SHIFT=010, HARD=011, SLT=100, XOR=101, AND=110, OR=111) and func_code (REDEF=00, LW=01, SW=10, BRANCH=11).
REQ-031 The same package SHALL hold the constants NOP_INSTR=9'h0CC and HALT_INSTR=9'h0CC, and the branch LUT contents.
REQ-032 A sub-module instr_rom (1024 x 9, combinational read, loaded from machine_code.txt) SHALL be instantiated inside instr_fetch.
REQ-033 The FSM state type SHALL be local to instr_fetch.

Verification
REQ-034 Test 1: ROM[0..2]=ADD, XOR, HALT; pulse start -> pc 0,1,2 on consecutive cycles, then done=1, instr_count=3, pc held at 2.
REQ-035 Test 2: stall high for 2 cycles at pc=5 -> instr=9'h0CC, instr_valid=0, pc stays 5, instr_count unchanged, then resumes at 5.
REQ-036 Test 3: branch at pc=8 with instr[3:0]=4'hE and branch_taken=1 -> next pc=6 without BRANCH_LUT_EN, or LUT[14] with it; with branch_taken=0 -> next pc=9.
REQ-037 Test 4: reset pulsed at pc=20 in RUN -> next cycle IDLE, pc=0, instr_valid=0; a later start reruns from pc 0.
REQ-038 Test 5: non-branch at pc=10'h3FF -> pc=0; start pulsed in RUN -> no effect; start in DONE -> restart, instr_count=0.
REQ-039 Test 6: program of 70000 non-halting instructions -> instr_count saturates at 16'hFFFF.
